// File: rtl/program_sequencer_if.sv
// Instruction bus between the program sequencer (master) and the
// 8-bit accumulator core (slave): one {cmd,arg} word per handshake,
// with the core's jam flag returned to the sequencer.
interface program_sequencer_if;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic       handshake;
    logic       jam;

    modport master (
        output cmd,
        output arg,
        output handshake,
        input  jam
    );

    modport slave (
        input  cmd,
        input  arg,
        input  handshake,
        output jam
    );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: holds a small {cmd,arg} program RAM and plays it out
// to the accumulator core, one single-cycle handshake per word followed by
// GAP wait cycles. A jam from the core freezes the sequencer in FAULT until
// reset and records the index of the last word issued.
module program_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    program_sequencer_if.master   bus,
    input  logic                  load_en,
    input  logic [AW-1:0]         load_addr,
    input  logic [15:0]           load_data,
    input  logic [AW:0]           prog_len,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [AW-1:0]         fault_pc,
    output logic [AW-1:0]         pc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [7:0]  CMD_NOP  = 8'h07;
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE = AW'(1);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP - 1);

    logic [15:0]   mem [DEPTH];

    logic [2:0]    state_q,    state_d;
    logic [7:0]    cmd_q,      cmd_d;
    logic [7:0]    arg_q,      arg_d;
    logic [AW-1:0] pc_q,       pc_d;
    logic [AW:0]   len_q,      len_d;
    logic [7:0]    gap_q,      gap_d;
    logic          done_q,     done_d;
    logic          fault_q,    fault_d;
    logic [AW-1:0] fault_pc_q, fault_pc_d;

    logic          mem_we;
    logic [AW-1:0] fetch_addr;
    logic [15:0]   fetch_word;
    logic [AW:0]   len_clamped;
    logic          last_word;

    // Program RAM write port; writes only land while no run is in flight.
    // NOTE: the RAM has no reset branch on purpose -- resetting a memory array
    // forces it into flops and the program contents are reloaded anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // Word fetch with write bypass so a load coinciding with start is seen by word 0.
    always_comb begin
        mem_we      = load_en && (state_q == S_IDLE || state_q == S_DONE);
        fetch_addr  = (state_q == S_WAIT) ? pc_q + PC_ONE : '0;
        fetch_word  = (mem_we && load_addr == fetch_addr) ? load_data : mem[fetch_addr];
        len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
        last_word   = ({1'b0, pc_q} == len_q - LEN_ONE);
    end

    // Next-state and datapath decisions for the run controller.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        pc_d       = pc_q;
        len_d      = len_q;
        gap_d      = gap_q;
        done_d     = done_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d = 1'b0;
                    len_d  = len_clamped;
                    if (bus.jam) begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = '0;
                    end else if (prog_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        pc_d    = '0;
                        cmd_d   = fetch_word[15:8];
                        arg_d   = fetch_word[7:0];
                    end
                end
            end
            S_ISSUE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    gap_d   = GAP_LOAD;
                end
            end
            S_WAIT: begin
                if (bus.jam) begin
                    state_d    = S_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    if (last_word) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        pc_d    = pc_q + PC_ONE;
                        cmd_d   = fetch_word[15:8];
                        arg_d   = fetch_word[7:0];
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                // FAULT: the core stays jammed until its own reset, so hold here.
            end
        endcase
    end

    // State and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_NOP;
            arg_q      <= '0;
            pc_q       <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.arg       = arg_q;
    assign bus.handshake = (state_q == S_ISSUE);
    assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done          = done_q;
    assign fault         = fault_q;
    assign fault_pc      = fault_pc_q;
    assign pc            = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a GAP=1 instance driving a small
// accumulator core model, and a GAP=3 instance sharing the same inputs.
module tb_program_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clr = 1'b0;

    logic          busy1, done1, fault1, busy3, done3, fault3;
    logic [AW-1:0] fault_pc1, pc1, fault_pc3, pc3;

    program_sequencer_if bus1 ();
    program_sequencer_if bus3 ();

    program_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start), .stop(stop),
        .busy(busy1), .done(done1), .fault(fault1), .fault_pc(fault_pc1), .pc(pc1)
    );

    program_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start), .stop(stop),
        .busy(busy3), .done(done3), .fault(fault3), .fault_pc(fault_pc3), .pc(pc3)
    );

    always #5 clk = ~clk;

    // Accumulator core model: 02 load, 04 add, 06 output, 07 nop, anything else jams.
    logic [7:0] acc, core_out;
    logic       core_jam;
    always @(posedge clk) begin
        if (rst) begin
            acc      <= 8'h00;
            core_out <= 8'h00;
            core_jam <= 1'b0;
        end else if (bus1.handshake) begin
            case (bus1.cmd)
                8'h02:   acc <= bus1.arg;
                8'h04:   acc <= acc + bus1.arg;
                8'h06:   core_out <= acc;
                8'h07:   ;
                default: core_jam <= 1'b1;
            endcase
        end
    end
    assign bus1.jam = core_jam;
    assign bus3.jam = 1'b0;

    // Handshake monitor for the GAP=1 instance: count, log words, check spacing.
    int         hs1, last1, cyc, gap_err1;
    logic [7:0] cmd_log [32];
    logic [7:0] arg_log [32];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            hs1      <= 0;
            gap_err1 <= 0;
        end else if (bus1.handshake) begin
            if (hs1 < 32) begin
                cmd_log[hs1] <= bus1.cmd;
                arg_log[hs1] <= bus1.arg;
            end
            if (hs1 != 0 && cyc - last1 != 2) gap_err1 <= gap_err1 + 1;
            last1 <= cyc;
            hs1   <= hs1 + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b1; load_en = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end1(input int bound, input string name);
        int n = 0;
        while (!(done1 || fault1) && n < bound) begin
            tick();
            n++;
        end
        n_checks++;
        if (!(done1 || fault1)) begin
            n_fail++;
            $display("FAIL %s_timeout: no done/fault within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus1.cmd !== 8'h07) begin n_fail++; $display("FAIL reset_cmd: got %h want 07", bus1.cmd); end
        n_checks++; if (bus1.arg !== 8'h00) begin n_fail++; $display("FAIL reset_arg: got %h want 00", bus1.arg); end
        n_checks++; if (bus1.handshake !== 1'b0) begin n_fail++; $display("FAIL reset_hs: got %b want 0", bus1.handshake); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done1); end
        n_checks++; if (fault1 !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault1); end
        n_checks++; if (fault_pc1 !== 4'd0) begin n_fail++; $display("FAIL reset_fault_pc: got %0d want 0", fault_pc1); end
        n_checks++; if (pc1 !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc1); end
    endtask

    task automatic test_run();
        do_reset();
        load_word(4'd0, 16'h0205);
        load_word(4'd1, 16'h0403);
        load_word(4'd2, 16'h0600);
        prog_len = 5'd3;
        pulse_start();
        wait_end1(50, "run");
        n_checks++; if (hs1 !== 3) begin n_fail++; $display("FAIL run_hs_count: got %0d want 3", hs1); end
        n_checks++; if (cmd_log[0] !== 8'h02 || cmd_log[1] !== 8'h04 || cmd_log[2] !== 8'h06) begin
            n_fail++; $display("FAIL run_cmd_seq: got %h %h %h want 02 04 06", cmd_log[0], cmd_log[1], cmd_log[2]); end
        n_checks++; if (gap_err1 !== 0) begin n_fail++; $display("FAIL run_spacing: got %0d bad gaps want 0", gap_err1); end
        n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL run_done: got %b want 1", done1); end
        n_checks++; if (core_out !== 8'h08) begin n_fail++; $display("FAIL run_core_out: got %h want 08", core_out); end
        n_checks++; if (pc1 !== 4'd2) begin n_fail++; $display("FAIL run_pc: got %0d want 2", pc1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL run_busy: got %b want 0", busy1); end
        n_checks++; if (bus1.cmd !== 8'h06) begin n_fail++; $display("FAIL run_cmd_hold: got %h want 06", bus1.cmd); end
    endtask

    task automatic test_jam();
        do_reset();
        load_word(4'd0, 16'h0201);
        load_word(4'd1, 16'hFF00);
        load_word(4'd2, 16'h0600);
        prog_len = 5'd3;
        pulse_start();
        wait_end1(50, "jam");
        n_checks++; if (fault1 !== 1'b1) begin n_fail++; $display("FAIL jam_fault: got %b want 1", fault1); end
        n_checks++; if (fault_pc1 !== 4'd1) begin n_fail++; $display("FAIL jam_fault_pc: got %0d want 1", fault_pc1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL jam_done: got %b want 0", done1); end
        repeat (6) tick();
        pulse_start();
        repeat (6) tick();
        n_checks++; if (hs1 !== 2) begin n_fail++; $display("FAIL jam_hs_count: got %0d want 2", hs1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL jam_start_ignored: busy got %b want 0", busy1); end
        n_checks++; if (fault1 !== 1'b1) begin n_fail++; $display("FAIL jam_fault_sticky: got %b want 1", fault1); end
    endtask

    task automatic test_len_bounds();
        do_reset();
        prog_len = 5'd0;
        pulse_start();
        n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", busy1); end
        repeat (4) tick();
        n_checks++; if (hs1 !== 0) begin n_fail++; $display("FAIL len0_hs: got %0d want 0", hs1); end
        for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 16'h0700);
        prog_len = 5'd20;
        pulse_start();
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL clamp_done_cleared: got %b want 0", done1); end
        wait_end1(100, "clamp");
        n_checks++; if (hs1 !== 16) begin n_fail++; $display("FAIL clamp_hs_count: got %0d want 16", hs1); end
        n_checks++; if (pc1 !== 4'd15) begin n_fail++; $display("FAIL clamp_pc: got %0d want 15", pc1); end
        n_checks++; if (gap_err1 !== 0) begin n_fail++; $display("FAIL clamp_spacing: got %0d bad gaps want 0", gap_err1); end
    endtask

    task automatic test_gap3();
        int n = 0, hs_n = 0, last = 0, done_n = -1, spacing_err = 0, busy_err = 0;
        do_reset();
        for (int i = 0; i < 4; i++) load_word(AW'(i), 16'h0700);
        prog_len = 5'd4;
        pulse_start();
        while (n < 60) begin
            if (done3) begin
                done_n = n;
                break;
            end
            if (bus3.handshake) begin
                if (hs_n > 0 && n - last != 4) spacing_err++;
                last = n;
                hs_n++;
            end
            if (!busy3) busy_err++;
            tick();
            n++;
        end
        n_checks++; if (hs_n !== 4) begin n_fail++; $display("FAIL gap3_hs_count: got %0d want 4", hs_n); end
        n_checks++; if (spacing_err !== 0) begin n_fail++; $display("FAIL gap3_spacing: got %0d bad gaps want 0", spacing_err); end
        n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL gap3_busy: got %0d idle cycles want 0", busy_err); end
        n_checks++; if (done_n - last !== 4) begin n_fail++; $display("FAIL gap3_done_lat: got %0d want 4", done_n - last); end
        n_checks++; if (pc3 !== 4'd3 || fault3 !== 1'b0 || fault_pc3 !== 4'd0) begin
            n_fail++; $display("FAIL gap3_final: pc %0d fault %b fault_pc %0d want 3 0 0", pc3, fault3, fault_pc3); end
    endtask

    task automatic test_stop();
        int n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) load_word(AW'(i), 16'h0700);
        prog_len = 5'd4;
        pulse_start();
        while (hs1 < 2 && n < 20) begin
            tick();
            n++;
        end
        n_checks++; if (busy1 !== 1'b1 || bus1.handshake !== 1'b0) begin
            n_fail++; $display("FAIL stop_in_wait: busy %b hs %b want 1 0", busy1, bus1.handshake); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (4) tick();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL stop_done: got %b want 0", done1); end
        n_checks++; if (pc1 !== 4'd1) begin n_fail++; $display("FAIL stop_pc: got %0d want 1", pc1); end
        n_checks++; if (hs1 !== 2) begin n_fail++; $display("FAIL stop_hs_count: got %0d want 2", hs1); end
    endtask

    task automatic test_load_collision();
        do_reset();
        load_word(4'd0, 16'h0700);
        load_word(4'd1, 16'h0403);
        load_word(4'd2, 16'h0600);
        prog_len = 5'd3;
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'h0209; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (bus1.cmd !== 8'h02 || bus1.arg !== 8'h09) begin
            n_fail++; $display("FAIL collide_word0: got %h%h want 0209", bus1.cmd, bus1.arg); end
        load_addr = 4'd1; load_data = 16'h0410;
        repeat (3) tick();
        load_en = 1'b0;
        wait_end1(50, "collide");
        n_checks++; if (core_out !== 8'h0C) begin n_fail++; $display("FAIL collide_out: got %h want 0C", core_out); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulse_start();
        wait_end1(50, "rerun");
        n_checks++; if (arg_log[1] !== 8'h03) begin n_fail++; $display("FAIL midrun_load_ignored: arg got %h want 03", arg_log[1]); end
        n_checks++; if (core_out !== 8'h0C) begin n_fail++; $display("FAIL rerun_out: got %h want 0C", core_out); end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        do_reset();
        load_word(4'd0, 16'h0201);
        load_word(4'd1, 16'h0401);
        load_word(4'd2, 16'h0401);
        load_word(4'd3, 16'h0600);
        prog_len = 5'd4;
        pulse_start();
        while (!(bus1.handshake && pc1 == 4'd2) && n < 20) begin
            tick();
            n++;
        end
        n_checks++; if (bus1.handshake !== 1'b1 || pc1 !== 4'd2) begin
            n_fail++; $display("FAIL rst_reach_word2: hs %b pc %0d want 1 2", bus1.handshake, pc1); end
        rst = 1'b1; clr = 1'b1;
        tick();
        n_checks++; if (bus1.handshake !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hs: got %b want 0", bus1.handshake); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy1); end
        n_checks++; if (bus1.cmd !== 8'h07) begin n_fail++; $display("FAIL rst_mid_cmd: got %h want 07", bus1.cmd); end
        n_checks++; if (pc1 !== 4'd0) begin n_fail++; $display("FAIL rst_mid_pc: got %0d want 0", pc1); end
        rst = 1'b0; clr = 1'b0;
        pulse_start();
        wait_end1(50, "rst_rerun");
        n_checks++; if (hs1 !== 4 || cmd_log[0] !== 8'h02) begin
            n_fail++; $display("FAIL rst_rerun_seq: hs %0d first cmd %h want 4 02", hs1, cmd_log[0]); end
        n_checks++; if (core_out !== 8'h03) begin n_fail++; $display("FAIL rst_rerun_out: got %h want 03", core_out); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_jam();
        test_len_bounds();
        test_gap3();
        test_stop();
        test_load_collision();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Initiator side of the cmd/arg/handshake instruction interface used by the team's 8-bit accumulator core.
- Holds a small program RAM of {cmd,arg} words, loaded over a simple write port.
- On start, it issues the words in order, one single-cycle handshake per word, with a fixed gap between words.
- Watches the core's jam output; on jam it stops and reports which word caused it.

Parameters:
- DEPTH, 16, number of program words; must be a power of two.
- AW, 4, address width; AW = log2(DEPTH).
- GAP, 1, number of WAIT cycles after each issue cycle; legal range 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- load_en  input  1  writes one program word; accepted only in IDLE or DONE.
- load_addr  input  AW  program word address.
- load_data  input  16  program word; [15:8] = cmd, [7:0] = arg.
- prog_len  input  AW+1  number of words to run; values above DEPTH are clamped to DEPTH.
- start  input  1  single-cycle pulse that begins a run.
- stop  input  1  aborts a run in progress.
- jam  input  1  jam flag from the core.
- cmd  output  8  command to the core (registered).
- arg  output  8  argument to the core (registered).
- handshake  output  1  high for exactly one cycle per issued word.
- busy  output  1  high in ISSUE and WAIT.
- done  output  1  sticky; set when a run completes, cleared by the next accepted start.
- fault  output  1  sticky; set on jam, cleared only by rst.
- fault_pc  output  AW  index of the word that was issued last before jam was seen.
- pc  output  AW  index of the current or last issued word.

Behaviour:
- Reset values: cmd=8'h07 (NOP), arg=0, handshake=0, busy=0, done=0, fault=0, fault_pc=0, pc=0; state=IDLE; gap counter=0. Program RAM contents are not reset.
- States: IDLE, ISSUE, WAIT, DONE, FAULT. busy=1 exactly in ISSUE and WAIT.
- Program RAM:
  - Write: mem[load_addr] <= load_data when load_en=1 and state is IDLE or DONE.
  - load_en in ISSUE, WAIT or FAULT is ignored.
- IDLE/DONE with start=1:
  - jam=1 -> FAULT, fault=1, fault_pc=0, no handshake.
  - else prog_len=0 -> DONE, done=1 next cycle, no handshake.
  - else -> ISSUE with pc=0, done=0, and {cmd,arg} loaded from mem[0].
- Write/start collision: a load_en write in the same cycle as start is committed before the first fetch and is visible to that run.
- ISSUE (one cycle):
  - handshake=1; cmd/arg hold mem[pc].
  - Next state is WAIT; handshake returns to 0; gap counter loads GAP-1.
- WAIT:
  - jam=1 in any WAIT cycle -> FAULT, fault=1, fault_pc=pc.
  - jam has priority over stop and over counter expiry.
  - Counter expires at 0:
    - pc = effective_len-1 -> DONE, done=1.
    - else pc increments, {cmd,arg} load mem[pc+1], and the state goes to ISSUE.
  - Word spacing: consecutive handshakes are exactly GAP+1 cycles apart.
- cmd/arg hold their last issued values in WAIT, DONE and FAULT.
- stop=1 in ISSUE or WAIT (and jam=0):
  - Next state is IDLE, done stays 0, pc is held.
  - A handshake already high in that ISSUE cycle still counts as issued.
- FAULT:
  - handshake=0; start, stop and load_en are all ignored; exit only via rst.
  - Reason: the core's jam is only cleared by the core's own reset.
- Clamping: effective_len = min(prog_len, DEPTH). prog_len is sampled only at accepted start; later changes have no effect on the current run.
- No pc wrap: a run of DEPTH words ends at pc=DEPTH-1, then DONE.
- rst in any state, including mid-handshake, returns all outputs to their reset values on the next edge.

Test Plan:
- Run with a core model, GAP=1: load {02,05},{04,03},{06,00}, prog_len=3, start -> 3 handshakes 2 cycles apart, cmd sequence 02,04,06; done=1; core out=8'h08; pc=2.
- Jam: load {02,01},{FF,00},{06,00}, prog_len=3, start -> 2 handshakes only; fault=1; fault_pc=1; no third handshake; start afterwards ignored.
- prog_len=0 and start -> done=1 one cycle later, handshake never asserted; prog_len=20 with DEPTH=16 -> exactly 16 handshakes.
- GAP=3, prog_len=4 -> handshakes 4 cycles apart, busy continuous, done after the last WAIT.
- stop during the WAIT after word 1 of 4 -> IDLE, done=0, 2 handshakes total; load_en issued mid-run does not alter RAM (verify by a rerun).
- rst asserted in the ISSUE cycle of word 2 -> next cycle handshake=0, busy=0, cmd=8'h07, pc=0; a fresh start reruns from word 0.
